// File: rtl/bus_arbiter.sv
// bus_arbiter: time-division arbiter for the shared 17-bit RAM bus.
// A 16-cycle frame on clk_sys_i is split into three slots:
//   cycles 0-3   video fetch  (VIDEO_BASE | video_addr_i, read)
//   cycles 4-7   SPI bridge   (IDLE/ACCESS/DONE four-phase handshake)
//   cycles 8-15  CPU access   (cpu_en_o pulses in cycle 15)
// Ports:
//   clk_sys_i, rst_ni              16 MHz clock, async active-low reset
//   spi_addr_i/data_i/rw_ni/valid_i bridge request in
//   spi_data_o, spi_ready_o         bridge read data / completion
//   cpu_addr_i, cpu_rw_ni, cpu_en_o CPU address, direction, clock enable
//   video_addr_i, video_data_o, video_strobe_o  video fetch
//   ram_addr_o, ram_data_i, ram_oe_no, ram_we_no, ram_data_oe_o  RAM bus
//   cycle_o                         frame cycle counter
// Every output is registered; the value shown in cycle N is computed
// from the counter's next value at the edge ending cycle N-1.
module bus_arbiter #(
  parameter logic [16:0] VIDEO_BASE = 17'h08000,
  parameter int unsigned VIDEO_AW   = 10
) (
  input  logic                clk_sys_i,
  input  logic                rst_ni,
  input  logic [16:0]         spi_addr_i,
  input  logic [7:0]          spi_data_i,
  input  logic                spi_rw_ni,
  input  logic                spi_valid_i,
  output logic [7:0]          spi_data_o,
  output logic                spi_ready_o,
  input  logic [16:0]         cpu_addr_i,
  input  logic                cpu_rw_ni,
  output logic                cpu_en_o,
  input  logic [VIDEO_AW-1:0] video_addr_i,
  output logic [7:0]          video_data_o,
  output logic                video_strobe_o,
  output logic [16:0]         ram_addr_o,
  input  logic [7:0]          ram_data_i,
  output logic                ram_oe_no,
  output logic                ram_we_no,
  output logic                ram_data_oe_o,
  output logic [3:0]          cycle_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } spi_state_t;

  spi_state_t  r_state, w_state_nxt;
  logic [3:0]  r_cycle, w_cyc_nxt;
  logic [16:0] r_spi_addr, w_spi_addr_nxt;
  logic        r_spi_rd, w_spi_rd_nxt;

  logic [16:0] r_ram_addr, w_ram_addr;
  logic        r_oe_n, w_oe_n;
  logic        r_we_n, w_we_n;
  logic        r_data_oe, w_data_oe;
  logic        r_cpu_en, r_spi_ready, r_video_strobe;
  logic [7:0]  r_spi_data, r_video_data;

  // Bridge write data reaches the RAM through the external data mux;
  // the arbiter only decides when it is driven.
  logic w_unused_wdata;
  assign w_unused_wdata = ^spi_data_i;

  // SPI FSM next state; requests are only taken at the edge ending cycle 3.
  always_comb begin
    w_cyc_nxt      = r_cycle + 4'd1;
    w_state_nxt    = r_state;
    w_spi_addr_nxt = r_spi_addr;
    w_spi_rd_nxt   = r_spi_rd;
    unique case (r_state)
      S_IDLE: begin
        if (r_cycle == 4'd3 && spi_valid_i) begin
          w_state_nxt    = S_ACCESS;
          w_spi_addr_nxt = spi_addr_i;
          w_spi_rd_nxt   = spi_rw_ni;
        end
      end
      S_ACCESS: begin
        if (r_cycle == 4'd7) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!spi_valid_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus strobes for the upcoming cycle, selected by slot.
  always_comb begin
    w_ram_addr = r_ram_addr;
    w_oe_n     = 1'b1;
    w_we_n     = 1'b1;
    w_data_oe  = 1'b0;
    if (w_cyc_nxt <= 4'd3) begin
      w_ram_addr = VIDEO_BASE | 17'(video_addr_i);
      w_oe_n     = 1'b0;
    end else if (w_cyc_nxt <= 4'd7) begin
      // Idle slot still presents the last latched bridge address.
      w_ram_addr = w_spi_addr_nxt;
      if (w_state_nxt == S_ACCESS) begin
        if (w_spi_rd_nxt) begin
          w_oe_n = 1'b0;
        end else begin
          w_data_oe = 1'b1;
          w_we_n    = !(w_cyc_nxt == 4'd5 || w_cyc_nxt == 4'd6);
        end
      end
    end else begin
      w_ram_addr = cpu_addr_i;
      if (cpu_rw_ni) begin
        w_oe_n = 1'b0;
      end else begin
        w_data_oe = 1'b1;
        w_we_n    = !(w_cyc_nxt >= 4'd10 && w_cyc_nxt <= 4'd14);
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycle        <= '0;
      r_state        <= S_IDLE;
      r_spi_addr     <= '0;
      r_spi_rd       <= 1'b1;
      r_ram_addr     <= '0;
      r_oe_n         <= 1'b1;
      r_we_n         <= 1'b1;
      r_data_oe      <= 1'b0;
      r_cpu_en       <= 1'b0;
      r_spi_ready    <= 1'b0;
      r_video_strobe <= 1'b0;
      r_spi_data     <= '0;
      r_video_data   <= '0;
    end else begin
      r_cycle        <= w_cyc_nxt;
      r_state        <= w_state_nxt;
      r_spi_addr     <= w_spi_addr_nxt;
      r_spi_rd       <= w_spi_rd_nxt;
      r_ram_addr     <= w_ram_addr;
      r_oe_n         <= w_oe_n;
      r_we_n         <= w_we_n;
      r_data_oe      <= w_data_oe;
      r_cpu_en       <= (w_cyc_nxt == 4'd15);
      r_spi_ready    <= (w_state_nxt == S_DONE);
      r_video_strobe <= (w_cyc_nxt == 4'd4);
      if (r_cycle == 4'd3) r_video_data <= ram_data_i;
      if (r_state == S_ACCESS && r_cycle == 4'd7 && r_spi_rd) r_spi_data <= ram_data_i;
    end
  end

  assign cycle_o        = r_cycle;
  assign ram_addr_o     = r_ram_addr;
  assign ram_oe_no      = r_oe_n;
  assign ram_we_no      = r_we_n;
  assign ram_data_oe_o  = r_data_oe;
  assign cpu_en_o       = r_cpu_en;
  assign spi_ready_o    = r_spi_ready;
  assign spi_data_o     = r_spi_data;
  assign video_strobe_o = r_video_strobe;
  assign video_data_o   = r_video_data;

endmodule
